// File: rtl/mem_access_unit_if.sv
// Pipeline/data-memory bundle for mem_access_unit: MEM-stage request, word-addressed
// data-memory port, stall and load-result signals. slave = the access unit, master = its environment.
interface mem_access_unit_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic [ADDR_W-1:0] dmem_adr;
  logic [31:0]       dmem_din;
  logic              dmem_we;
  logic              dmem_re;
  logic [31:0]       dmem_dout;

  logic              stall;
  logic [31:0]       rdata;
  logic              rdata_valid;
  logic              misalign_err;
  logic              bounds_err;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, dmem_dout,
    output dmem_adr, dmem_din, dmem_we, dmem_re, stall, rdata, rdata_valid,
           misalign_err, bounds_err
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, dmem_dout,
    input  dmem_adr, dmem_din, dmem_we, dmem_re, stall, rdata, rdata_valid,
           misalign_err, bounds_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: byte/half/word loads and stores onto a word-only data memory,
// sub-word stores via a two-cycle read-modify-write. Define MAU_BOUNDS_EN for range checking.
module mem_access_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);
  typedef enum logic [0:0] {IDLE, RMW_WR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] held_adr;
  logic [31:0]       merge_q;

  logic              is_word;
  logic              is_half;
  logic              misaligned;
  logic              out_of_range;
  logic              idle_req;
  logic              accept;
  logic              load;
  logic              word_store;
  logic              sub_store;
  logic [ADDR_W-1:0] req_word;
  logic [31:0]       lane_sh;
  logic [31:0]       lane_ext;
  logic [31:0]       merged;

  assign is_word    = bus.req_size[1];
  assign is_half    = (bus.req_size == 2'b01);
  assign misaligned = (is_half & bus.req_addr[0]) | (is_word & (|bus.req_addr[1:0]));
  assign req_word   = bus.req_addr[ADDR_W+1:2];

`ifdef MAU_BOUNDS_EN
  assign out_of_range = |bus.req_addr[31:ADDR_W+2];
`else
  // Upper address bits are deliberately ignored so accesses wrap within the memory.
  logic unused_upper_addr;
  assign unused_upper_addr = ^bus.req_addr[31:ADDR_W+2];
  assign out_of_range      = 1'b0;
`endif

  // Strobes are qualified with rst_n so nothing reaches the memory or hazard unit during reset.
  assign idle_req   = (state == IDLE) & bus.req_valid & rst_n;
  assign accept     = idle_req & ~misaligned & ~out_of_range;
  assign load       = accept & ~bus.req_write;
  assign word_store = accept &  bus.req_write &  is_word;
  assign sub_store  = accept &  bus.req_write & ~is_word;

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    bus.dmem_adr = req_word;
    bus.dmem_din = bus.req_wdata;
    bus.dmem_we  = word_store;
    bus.dmem_re  = load | sub_store;
    bus.stall    = sub_store;
    if (state == RMW_WR) begin
      bus.dmem_adr = held_adr;
      bus.dmem_din = merge_q;
      bus.dmem_we  = 1'b1;
      bus.dmem_re  = 1'b0;
      bus.stall    = 1'b0;
    end
  end

  // Little-endian lane select; aligned halves sit at shift 0 or 16.
  always_comb begin
    lane_sh = bus.dmem_dout >> {bus.req_addr[1:0], 3'b000};
    case (bus.req_size)
      2'b00:   lane_ext = {{24{bus.req_signed & lane_sh[7]}},  lane_sh[7:0]};
      2'b01:   lane_ext = {{16{bus.req_signed & lane_sh[15]}}, lane_sh[15:0]};
      default: lane_ext = bus.dmem_dout;
    endcase
  end

  always_comb begin
    merged = bus.dmem_dout;
    if (is_half) begin
      if (bus.req_addr[1]) merged[31:16] = bus.req_wdata[15:0];
      else                 merged[15:0]  = bus.req_wdata[15:0];
    end else begin
      case (bus.req_addr[1:0])
        2'd0:    merged[7:0]   = bus.req_wdata[7:0];
        2'd1:    merged[15:8]  = bus.req_wdata[7:0];
        2'd2:    merged[23:16] = bus.req_wdata[7:0];
        default: merged[31:24] = bus.req_wdata[7:0];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      held_adr         <= '0;
      merge_q          <= '0;
      bus.rdata        <= '0;
      bus.rdata_valid  <= 1'b0;
      bus.misalign_err <= 1'b0;
      bus.bounds_err   <= 1'b0;
    end else begin
      bus.rdata_valid  <= load;
      bus.misalign_err <= idle_req & misaligned & ~out_of_range;
      bus.bounds_err   <= idle_req & out_of_range;
      if (load) bus.rdata <= lane_ext;
      case (state)
        IDLE: begin
          if (sub_store) begin
            merge_q  <= merged;
            held_adr <= req_word;
            state    <= RMW_WR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits in the MEM stage, directly upstream of the word-addressed data memory.
- Converts pipeline byte addresses to word addresses and handles all load/store sizes: byte, half and word.
- Sub-word stores use a two-cycle read-modify-write, because the data memory only writes whole words.
- Returns sign- or zero-extended load data and drives a stall to the hazard unit during read-modify-write.

Parameters:
- ADDR_W, 5, word-address width presented to the data memory (depth 2^ADDR_W words).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  memory op present in the MEM stage.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_signed  input  1  load sign-extends when 1.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- dmem_adr  output  ADDR_W  word address, req_addr[ADDR_W+1:2].
- dmem_din  output  32  write data to the data memory.
- dmem_we  output  1  data memory write enable.
- dmem_re  output  1  data memory read strobe.
- dmem_dout  input  32  combinational read data from the data memory.
- stall  output  1  holds earlier pipeline stages.
- rdata  output  32  extended load result (registered).
- rdata_valid  output  1  one-cycle pulse with rdata.
- misalign_err  output  1  one-cycle pulse on a misaligned access.
- bounds_err  output  1  one-cycle pulse on an out-of-range address; tied 0 unless MAU_BOUNDS_EN.

Behaviour:
- Reset: state IDLE; rdata, rdata_valid, misalign_err, bounds_err and the merge register are all 0. dmem_we=0 and stall=0 while rst_n is low.
- States: IDLE, RMW_WR.
- Lanes are little-endian: addr[1:0]=0 selects bits 7:0, 1 selects 15:8, and so on. A half at addr[1]=1 is bits 31:16.
- Alignment:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - A misaligned access is suppressed: no we, no rdata_valid. misalign_err pulses on the next cycle.
- IDLE, load: dmem_re=1 combinationally. The selected lane is extended and registered at the edge; rdata/rdata_valid appear the next cycle. Latency 1, no stall.
- IDLE, word store: dmem_we=1, dmem_din=req_wdata in the same cycle. No stall; stays in IDLE.
- IDLE, byte/half store (aligned):
  - stall=1 and dmem_re=1 combinationally in the accept cycle.
  - At the edge, the merge register is loaded with dmem_dout, target lane replaced by req_wdata[7:0] or [15:0].
  - Next state is RMW_WR.
- RMW_WR:
  - dmem_we=1, dmem_din=merge register, dmem_adr from the held request, stall=0.
  - Returns to IDLE. The held request is not re-accepted in this cycle.
- req_valid=0 in IDLE: no strobes asserted, no state change.
- rdata keeps its last value between loads. rdata_valid, misalign_err and bounds_err are single-cycle pulses.
- Async reset asserted in RMW_WR: the state goes to IDLE immediately, dmem_we drops at once, and the pending write is lost.

Optional Feature:
- MAU_BOUNDS_EN defined:
  - Any access with req_addr[31:ADDR_W+2]!=0 is suppressed: no we, no re, no stall, no rdata_valid.
  - bounds_err pulses next cycle.
  - If the access is both misaligned and out of range, bounds_err takes priority and misalign_err stays 0.
- Undefined: upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes, and bounds_err is constant 0.

Test Plan:
- sw addr 0x0C data 0xAABBCCDD:
  - dmem_we pulses 1 cycle with dmem_adr=3 and no stall.
  - Then lw 0x0C gives rdata=0xAABBCCDD with rdata_valid 1 cycle later.
- lb 0x0D signed gives rdata=0xFFFFFFCC; lbu 0x0D gives 0x000000CC.
- sb 0x0E data 0x11:
  - stall=1 for exactly 1 cycle, then dmem_we with dmem_din=0xAA11CCDD.
  - lh 0x0E signed then gives 0xFFFFAA11.
- sh 0x0F and lw 0x0D:
  - misalign_err pulses once per access; no dmem_we, no rdata_valid.
  - Word 3 is unchanged.
- sb 0x0C data 0x55 with rst_n pulled low during RMW_WR: dmem_we is never high, and after reset lw 0x0C still returns 0xAA11CCDD.
- Address 0x80:
  - With MAU_BOUNDS_EN: sw 0x80 gives a bounds_err pulse and memory is untouched.
  - Without it: sw 0x80 data 0x12345678 writes word 0, and lw 0x00 returns 0x12345678.
